// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - ALU operation encoding shared by id_stage and execute
package id_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

endpackage

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I ALU-class decode/operand fetch with register file and registered output
// Optional writeback-to-operand forwarding in the capture cycle: define ID_WB_BYPASS_EN.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output alu_op_t         ex_alu_op,
    output logic [XLEN-1:0] ex_opA,
    output logic [XLEN-1:0] ex_opB,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]      opcode;
    logic [4:0]      rd_idx;
    logic [2:0]      funct3;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    logic [XLEN-1:0] rf [32];
    logic [XLEN-1:0] rf_rs1;
    logic [XLEN-1:0] rf_rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            wb_active;

    alu_op_t         dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_ill;
    logic            dec_we;
    logic            capture;

    assign opcode  = if_instr[6:0];
    assign rd_idx  = if_instr[11:7];
    assign funct3  = if_instr[14:12];
    assign rs1_idx = if_instr[19:15];
    assign rs2_idx = if_instr[24:20];
    assign funct7  = if_instr[31:25];
    assign imm_i   = XLEN'($signed(if_instr[31:20]));
    assign imm_u   = XLEN'($signed({if_instr[31:12], 12'b0}));

    assign wb_active = wb_we && (wb_rd != 5'd0);

    // Entry 0 exists for uniform indexing but is never written and never read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_active) begin
            rf[wb_rd] <= wb_data;
        end
    end

    assign rf_rs1 = (rs1_idx == 5'd0) ? '0 : rf[rs1_idx];
    assign rf_rs2 = (rs2_idx == 5'd0) ? '0 : rf[rs2_idx];

`ifdef ID_WB_BYPASS_EN
    assign rs1_val = (wb_active && (wb_rd == rs1_idx)) ? wb_data : rf_rs1;
    assign rs2_val = (wb_active && (wb_rd == rs2_idx)) ? wb_data : rf_rs2;
`else
    assign rs1_val = rf_rs1;
    assign rs2_val = rf_rs2;
`endif

    function automatic alu_op_t base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec_op  = ALU_ADD;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_val;
                dec_b = rs2_val;
                if (funct7 == F7_BASE) begin
                    dec_op = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_op = ALU_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_a  = rs1_val;
                dec_b  = imm_i;
                dec_op = base_op(funct3);
                // Shift immediates reuse imm[11:5] as funct7; other funct3 take any imm.
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    dec_ill = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_op = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_ill = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = if_pc;
                dec_b = imm_u;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        if (dec_ill) begin
            dec_op = ALU_ADD;
            dec_a  = '0;
            dec_b  = '0;
        end
    end

    assign dec_we   = !dec_ill && (rd_idx != 5'd0);
    assign if_ready = !ex_valid || ex_ready;
    assign capture  = if_valid && if_ready;

    // Flush wins over capture; an instruction handshaked during flush is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_alu_op  <= ALU_ADD;
            ex_opA     <= '0;
            ex_opB     <= '0;
            ex_rd      <= 5'd0;
            ex_rd_we   <= 1'b0;
            ex_pc      <= '0;
            ex_illegal <= 1'b0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (capture) begin
                ex_valid <= 1'b1;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
            if (capture && !flush) begin
                ex_alu_op  <= dec_op;
                ex_opA     <= dec_a;
                ex_opB     <= dec_b;
                ex_rd      <= rd_idx;
                ex_rd_we   <= dec_we;
                ex_pc      <= if_pc;
                ex_illegal <= dec_ill;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed and randomized checks of id_stage against a behavioural model
module tb_id_stage;
    import id_stage_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic            ex_ready;
    alu_op_t         ex_alu_op;
    logic [XLEN-1:0] ex_opA;
    logic [XLEN-1:0] ex_opB;
    logic [4:0]      ex_rd;
    logic            ex_rd_we;
    logic [XLEN-1:0] ex_pc;
    logic            ex_illegal;

    id_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
        .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_pc(ex_pc), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_rf [32];
    logic        m_valid;
    alu_op_t     m_op;
    logic [31:0] m_a, m_b, m_pc;
    logic [4:0]  m_rd;
    logic        m_we, m_ill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd, input int opc);
        enc_r = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_rd == idx) return wb_data;
`endif
        return m_rf[idx];
    endfunction

    // Reference decode straight from the ISA rules for the supported subset.
    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] v1, input logic [31:0] v2,
                                       output alu_op_t op, output logic [31:0] a,
                                       output logic [31:0] b, output logic ill);
        alu_op_t ops [8];
        int opc = int'(ins[6:0]);
        int f3  = int'(ins[14:12]);
        int f7  = int'(ins[31:25]);
        logic signed [31:0] simm = $signed(ins) >>> 20;
        logic [31:0] uimm = ins & 32'hFFFF_F000;
        ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        ill = 1'b1; op = ALU_ADD; a = 0; b = 0;
        if (opc == 'h33) begin
            if (f7 == 0) begin
                ill = 1'b0; op = ops[f3];
            end else if (f7 == 'h20 && f3 == 0) begin
                ill = 1'b0; op = ALU_SUB;
            end else if (f7 == 'h20 && f3 == 5) begin
                ill = 1'b0; op = ALU_SRA;
            end
            if (!ill) begin a = v1; b = v2; end
        end else if (opc == 'h13) begin
            ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
            if (!ill) begin
                if (f3 == 5 && f7 == 'h20) op = ALU_SRA;
                else op = ops[f3];
                a = v1; b = simm;
            end
        end else if (opc == 'h37) begin
            ill = 1'b0; b = uimm;
        end else if (opc == 'h17) begin
            ill = 1'b0; a = pc; b = uimm;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_valid = 0; m_op = ALU_ADD; m_a = 0; m_b = 0; m_pc = 0; m_rd = 0; m_we = 0; m_ill = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, ex_valid, 0);
        chk({tag, "_op"}, 32'(ex_alu_op), 32'(ALU_ADD));
        chk({tag, "_opA"}, ex_opA, 0);
        chk({tag, "_opB"}, ex_opB, 0);
        chk({tag, "_pc"}, ex_pc, 0);
        chk({tag, "_rd"}, ex_rd, 0);
        chk({tag, "_rd_we"}, ex_rd_we, 0);
        chk({tag, "_ill"}, ex_illegal, 0);
        chk({tag, "_if_ready"}, if_ready, 1);
    endtask

    task automatic compare_outputs();
        chk("ex_valid", ex_valid, m_valid);
        if (m_valid) begin
            chk("ex_alu_op", 32'(ex_alu_op), 32'(m_op));
            chk("ex_opA", ex_opA, m_a);
            chk("ex_opB", ex_opB, m_b);
            chk("ex_rd", ex_rd, m_rd);
            chk("ex_rd_we", ex_rd_we, m_we);
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_illegal", ex_illegal, m_ill);
        end
    endtask

    // One clock: inputs are already set; predict, clock, compare.
    task automatic tick();
        logic cap, nv, ill;
        alu_op_t op;
        logic [31:0] a, b;
        #1;
        chk("if_ready", if_ready, !m_valid || ex_ready);
        cap = if_valid && (!m_valid || ex_ready);
        ref_decode(if_instr, if_pc, read_reg(if_instr[19:15]), read_reg(if_instr[24:20]), op, a, b, ill);
        nv = flush ? 1'b0 : cap ? 1'b1 : ex_ready ? 1'b0 : m_valid;
        if (cap && !flush) begin
            m_op = op; m_a = a; m_b = b; m_ill = ill; m_pc = if_pc;
            m_rd = if_instr[11:7]; m_we = !ill && (if_instr[11:7] != 0);
        end
        m_valid = nv;
        if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        wb_we = 1; wb_rd = idx; wb_data = data; if_valid = 0;
        tick();
        wb_we = 0;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1; if_instr = ins; if_pc = pc;
        tick();
        if_valid = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 9);
        int j = $urandom_range(0, 3);
        if (k <= 3) r[6:0] = 7'h33;
        else if (k <= 6) r[6:0] = 7'h13;
        else if (k == 7) r[6:0] = 7'h37;
        else if (k == 8) r[6:0] = 7'h17;
        if (j <= 1) r[31:25] = 7'h00;
        else if (j == 2) r[31:25] = 7'h20;
        return r;
    endfunction

    localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;

    initial begin
        rst_n = 0; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; ex_ready = 0;
        model_reset();
        #1;
        chk_reset_outputs("in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        chk_reset_outputs("after_reset");

        ex_ready = 1;
        wr(5'd1, 32'd5);
        wr(5'd2, 32'd7);
        offer(ADD_3_1_2, 32'h40);
        chk("add_valid", ex_valid, 1);
        chk("add_op", 32'(ex_alu_op), 32'(ALU_ADD));
        chk("add_opA", ex_opA, 5);
        chk("add_opB", ex_opB, 7);
        chk("add_rd", ex_rd, 3);
        chk("add_rd_we", ex_rd_we, 1);

        offer(ADD_3_1_2, 32'h44);
        ex_ready = 0;
        if_valid = 1; if_instr = 32'hFFF08213; if_pc = 32'h48;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_if_ready", if_ready, 0);
            chk("stall_pc", ex_pc, 32'h44);
            chk("stall_opB", ex_opB, 7);
        end
        if_valid = 0; ex_ready = 1;
        tick();

        offer(32'hFFF08213, 32'h50);
        chk("addi_opB", ex_opB, 32'hFFFF_FFFF);
        offer(32'h4030D293, 32'h54);
        chk("srai_op", 32'(ex_alu_op), 32'(ALU_SRA));
        chk("srai_shamt", ex_opB[4:0], 3);
        offer(32'hABCDE337, 32'h58);
        chk("lui_opA", ex_opA, 0);
        chk("lui_opB", ex_opB, 32'hABCD_E000);
        offer(32'h00001397, 32'h100);
        chk("auipc_opA", ex_opA, 32'h100);
        chk("auipc_opB", ex_opB, 32'h1000);

        offer(enc_r('h20, 2, 1, 1, 3, 'h33), 32'h104);
        chk("ill_f7_ill", ex_illegal, 1);
        chk("ill_f7_we", ex_rd_we, 0);
        offer(32'h0000A183, 32'h108);
        chk("ill_opc_ill", ex_illegal, 1);
        chk("ill_opc_we", ex_rd_we, 0);
        offer(enc_r(0, 2, 1, 0, 0, 'h33), 32'h10C);
        chk("add_x0_ill", ex_illegal, 0);
        chk("add_x0_we", ex_rd_we, 0);

        wb_we = 1; wb_rd = 5'd1; wb_data = 32'h55;
        offer(ADD_3_1_2, 32'h110);
        wb_we = 0;
`ifdef ID_WB_BYPASS_EN
        chk("bypass_opA", ex_opA, 32'h55);
`else
        chk("bypass_opA", ex_opA, 32'd5);
`endif
        offer(ADD_3_1_2, 32'h114);
        chk("after_wb_opA", ex_opA, 32'h55);
        wr(5'd0, 32'h55);
        offer(enc_r(0, 2, 0, 0, 3, 'h33), 32'h118);
        chk("x0_read", ex_opA, 0);
        wb_we = 1; wb_rd = 5'd0; wb_data = 32'h55;
        offer(enc_r(0, 2, 0, 0, 3, 'h33), 32'h11C);
        wb_we = 0;
        chk("x0_bypass", ex_opA, 0);

        offer(ADD_3_1_2, 32'h80);
        ex_ready = 0;
        tick();
        flush = 1; if_valid = 1; if_instr = 32'hABCDE337; if_pc = 32'h84;
        tick();
        flush = 0; if_valid = 0;
        chk("flush_stall_valid", ex_valid, 0);
        ex_ready = 1;
        tick();
        chk("flush_stall_gone", ex_valid, 0);
        flush = 1; if_valid = 1; if_instr = 32'hABCDE337; if_pc = 32'h88;
        tick();
        flush = 0; if_valid = 0;
        chk("flush_hs_valid", ex_valid, 0);
        tick();
        chk("flush_hs_gone", ex_valid, 0);

        for (int n = 0; n < 3000; n++) begin
            if_valid = $urandom_range(0, 3) != 0;
            if_instr = rand_instr();
            if_pc = $urandom & 32'hFFFF_FFFC;
            ex_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            wb_we = $urandom_range(0, 1) == 1;
            wb_rd = ($urandom_range(0, 1) == 1) ? if_instr[19:15] : 5'($urandom);
            wb_data = $urandom;
            tick();
        end
        if_valid = 0; flush = 0; wb_we = 0;

        ex_ready = 1;
        offer(ADD_3_1_2, 32'h200);
        ex_ready = 0;
        tick();
        chk("pre_reset_valid", ex_valid, 1);
        #3;
        rst_n = 0;
        #1;
        chk_reset_outputs("mid_stall_reset");
        model_reset();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        ex_ready = 1;
        offer(ADD_3_1_2, 32'h300);
        chk("rf_cleared_opA", ex_opA, 0);
        chk("rf_cleared_opB", ex_opB, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode/operand-fetch stage directly upstream of the ALU. Accepts one instruction per handshake from fetch and decodes the RV32I ALU-class subset (OP, OP-IMM, LUI, AUIPC) into an `alu_op_t` plus two operands. Owns the 32×XLEN integer register file, which is written by writeback. Presents results to the execute stage through a registered valid/ready output.

## Interface
- `XLEN`, 32, datapath and register width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `if_valid`  in  1  fetch offers an instruction.
- `if_ready`  out  1  stage can accept an instruction this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  XLEN  PC of `if_instr`.
- `flush`  in  1  discard the output-register contents and any instruction accepted this cycle.
- `wb_we`  in  1  register-file write enable.
- `wb_rd`  in  5  write index.
- `wb_data`  in  XLEN  write data.
- `ex_valid`  out  1  output register holds a decoded instruction.
- `ex_ready`  in  1  execute consumes the output this cycle.
- `ex_alu_op`  out  alu_op_t  operation for the ALU.
- `ex_opA`, `ex_opB`  out  XLEN  ALU operands.
- `ex_rd`  out  5  destination index.
- `ex_rd_we`  out  1  destination write enable.
- `ex_pc`  out  XLEN  PC of the held instruction.
- `ex_illegal`  out  1  held instruction is outside the supported subset.

## Operation
- **Register file:** 32 entries.
  - Write on the clock edge when `wb_we && wb_rd != 0`; writes to x0 are ignored.
  - x0 always reads 0.
  - Reads are combinational from the rs1 (`[19:15]`) and rs2 (`[24:20]`) fields.
- **OP (0110011):** opA = rs1, opB = rs2.
  - funct3 selects ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - funct7 0000000 is legal with any funct3.
  - Any other funct7 is illegal.
- **OP-IMM (0010011):** opA = rs1, opB = sign-extended `instr[31:20]`.
  - SLLI requires funct7 0000000.
  - SRLI requires funct7 0000000; SRAI requires funct7 0100000. Otherwise illegal.
  - For shifts, opB carries the full immediate; the ALU uses only `[4:0]`.
- **LUI (0110111):** op = ALU_ADD, opA = 0, opB = `{instr[31:12], 12'b0}`.
- **AUIPC (0010111):** op = ALU_ADD, opA = `if_pc`, opB = `{instr[31:12], 12'b0}`.
- **Destination:** `ex_rd = instr[11:7]`. `ex_rd_we` = 1 for legal instructions with rd ≠ 0, otherwise 0.
- **Illegal instructions** (any other opcode or bad funct7): `ex_illegal` = 1, op = ALU_ADD, opA = opB = 0, `ex_rd_we` = 0. The instruction still passes through the handshake.
- **Handshake:**
  - `if_ready = !ex_valid || ex_ready`.
  - Capture happens on `if_valid && if_ready`.
  - While `ex_valid && !ex_ready`, all `ex_*` outputs hold stable.
  - `ex_valid` falls when the output is consumed and no new instruction is captured.
- **Flush:**
  - Next cycle `ex_valid` = 0, overriding any capture.
  - `if_ready` is unaffected, so an instruction handshaked during the flush cycle is consumed and dropped.
  - The register file is unaffected.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `ex_*` after edge N.
- Throughput is 1 instruction per cycle when `ex_ready` is held high.
- Operands are sampled at capture and are not re-read while stalled.
- Reset values: `ex_valid` 0, `ex_alu_op` ALU_ADD, `ex_opA`/`ex_opB`/`ex_pc` 0, `ex_rd` 0, `ex_rd_we` 0, `ex_illegal` 0, all register-file entries 0.
- `if_ready` is 1 out of reset.
- Reset mid-stall drops the held instruction.
- Simultaneous capture and a `wb_we` to a source register: the result depends on the configuration macro below.

## Configuration
- `ID_WB_BYPASS_EN`
  - **Defined:** if `wb_we && wb_rd != 0 && wb_rd == rsN` in the capture cycle, the operand uses `wb_data`.
  - **Undefined:** the operand takes the pre-write register value. The new value is visible from the following cycle.
  - In both cases the register-file write itself is identical.

## Test plan
- **Basic ADD with back-pressure:**
  - Stimulus: write x1 = 5, x2 = 7, then offer `ADD x3,x1,x2` (0x002081B3) with `ex_ready` = 1.
  - Required: next cycle `ex_valid` = 1, op ALU_ADD, opA = 5, opB = 7, rd = 3, `rd_we` = 1.
  - Stimulus: repeat with `ex_ready` = 0 for 3 cycles.
  - Required: outputs held and `if_ready` = 0 throughout.
- **Immediates:**
  - `ADDI x4,x1,-1` → opB = 0xFFFFFFFF.
  - `SRAI x5,x1,3` → op ALU_SRA, opB[4:0] = 3.
  - `LUI x6,0xABCDE` → opA = 0, opB = 0xABCDE000.
  - `AUIPC` at pc 0x100 with imm 1 → opA = 0x100, opB = 0x1000.
- **Illegal instructions:**
  - funct7 0100000 with funct3 001 → `ex_illegal` = 1, `rd_we` = 0.
  - Opcode 0000011 → `ex_illegal` = 1, `rd_we` = 0.
  - `ADD x0,...` → `rd_we` = 0, `ex_illegal` = 0.
- **Bypass:**
  - Stimulus: capture `ADD x3,x1,x2` in the same cycle as `wb_we`, x1 ← 0x55.
  - Required: opA = 0x55 with `ID_WB_BYPASS_EN` defined, otherwise the old x1.
  - Stimulus: `wb_rd` = 0 with `wb_data` 0x55.
  - Required: x0 still reads 0.
- **Flush:**
  - Stimulus: stall with `ex_valid` = 1, assert `flush` together with `if_valid`.
  - Required: next cycle `ex_valid` = 0 and the offered instruction never appears.
- **Reset:**
  - Stimulus: assert `rst_n` = 0 asynchronously mid-stall.
  - Required: all outputs go to their reset values immediately and the register file reads 0.
